decoder_rr_arbiter: RTL and testbench



---
 rtl/decoder_rr_arbiter_pkg.sv | 13 +
 rtl/decoder_rr_arbiter_if.sv | 21 ++
 rtl/decoder_rr_arbiter_dec.sv | 11 +
 rtl/decoder_rr_arbiter.sv | 106 ++++++++++
 tb/tb_decoder_rr_arbiter.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared encodings and sizes for the round-robin decoder arbiter.
package decoder_rr_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int SEL_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
interface decoder_rr_arbiter_if;
    import decoder_rr_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [SEL_W-1:0]   sel;
    logic               sel_en;
    logic [NUM_REQ-1:0] gnt;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        input  sel, sel_en, gnt, busy, timeout
    );

    modport slave (
        input  req,
        output sel, sel_en, gnt, busy, timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter_dec.sv
// Existing 3-to-8 decoder: one-hot Out from A, all zeros when E is low.
module threeToEightDecoder (
    input  logic [2:0] A,
    input  logic       E,
    output logic [7:0] Out
);
    always_comb begin
        Out = 8'h00;
        if (E) Out = 8'h01 << A;
    end
endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin owner selection for a shared 3-to-8 decoder bank, with a
// bounded hold time and a one-cycle dead gap between consecutive owners.
module decoder_rr_arbiter
    import decoder_rr_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 15,
    parameter int CNT_W    = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    decoder_rr_arbiter_if.slave   bus
);

    // Returns {found, index}: first set request at or after ptr, wrapping 7->0.
    function automatic logic [SEL_W:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [SEL_W-1:0]   p);
        logic [SEL_W-1:0] idx;
        logic [SEL_W:0]   res;
        res = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = p + SEL_W'(i);
            if (r[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    arb_state_t         state;
    logic [SEL_W-1:0]   ptr;
    logic [SEL_W-1:0]   sel;
    logic               sel_en;
    logic               busy;
    logic               timeout;
    logic [CNT_W-1:0]   hold_cnt;
    logic [SEL_W:0]     pick;
    logic               owner_req;
    logic               hold_max;
    logic [NUM_REQ-1:0] gnt_dec;

    always_comb begin
        pick      = rr_pick(bus.req, ptr);
        owner_req = bus.req[sel];
        hold_max  = (hold_cnt == CNT_W'(MAX_HOLD));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            sel_en   <= 1'b0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= '0;
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE, GAP: begin
                    if (pick[SEL_W]) begin
                        state    <= GRANT;
                        sel      <= pick[SEL_W-1:0];
                        sel_en   <= 1'b1;
                        busy     <= 1'b1;
                        hold_cnt <= CNT_W'(1);
                    end else begin
                        state    <= IDLE;
                        sel_en   <= 1'b0;
                        busy     <= 1'b0;
                        hold_cnt <= '0;
                    end
                end
                GRANT: begin
                    if (!owner_req || hold_max) begin
                        // Only a forced release (owner still requesting) flags timeout.
                        state    <= GAP;
                        sel_en   <= 1'b0;
                        busy     <= 1'b0;
                        ptr      <= sel + SEL_W'(1);
                        timeout  <= owner_req;
                        hold_cnt <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state    <= IDLE;
                    sel_en   <= 1'b0;
                    busy     <= 1'b0;
                    hold_cnt <= '0;
                end
            endcase
        end
    end

    threeToEightDecoder u_dec (
        .A   (sel),
        .E   (sel_en),
        .Out (gnt_dec)
    );

    assign bus.sel     = sel;
    assign bus.sel_en  = sel_en;
    assign bus.gnt     = gnt_dec;
    assign bus.busy    = busy;
    assign bus.timeout = timeout;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter with default MAX_HOLD=15, CNT_W=4.
module tb_decoder_rr_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    decoder_rr_arbiter_if bus ();

    decoder_rr_arbiter #(
        .MAX_HOLD (15),
        .CNT_W    (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Observed word is {gnt, busy, timeout, sel_en}; sel_en must follow |gnt.
    task automatic expect_st(input string tag, input logic [7:0] g,
                             input logic b, input logic t);
        logic [10:0] obs;
        logic [10:0] exp;
        obs = {bus.gnt, bus.busy, bus.timeout, bus.sel_en};
        exp = {g, b, t, |g};
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed gnt/busy/timeout/sel_en=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic expect_sel(input string tag, input logic [2:0] s);
        checks++;
        assert (bus.sel === s)
        else begin
            errors++;
            $error("FAIL %s: observed sel=%0d required %0d", tag, bus.sel, s);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus.req = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        expect_st("reset_state", 8'h00, 1'b0, 1'b0);
        expect_sel("reset_sel", 3'd0);
        reset = 1'b0;

        // Single requester: grant one edge after request, then GAP, then IDLE.
        tick();
        expect_st("idle_no_req", 8'h00, 1'b0, 1'b0);
        bus.req = 8'b0000_0100;
        tick();
        expect_st("single_grant", 8'h04, 1'b1, 1'b0);
        expect_sel("single_sel", 3'd2);
        bus.req = 8'h00;
        tick();
        expect_st("single_gap", 8'h00, 1'b0, 1'b0);
        tick();
        expect_st("single_idle", 8'h00, 1'b0, 1'b0);

        // Priority pointer: ptr=3 -> owner 5; after release ptr=6 wraps to 0.
        bus.req = 8'b0010_0000;
        tick();
        expect_st("ptr_owner5", 8'h20, 1'b1, 1'b0);
        bus.req = 8'b0001_0001;
        tick();
        expect_st("ptr_gap", 8'h00, 1'b0, 1'b0);
        tick();
        expect_st("ptr_wrap_to0", 8'h01, 1'b1, 1'b0);
        expect_sel("ptr_wrap_sel", 3'd0);
        bus.req = 8'h00;
        tick();
        expect_st("ptr_release_gap", 8'h00, 1'b0, 1'b0);
        tick();
        expect_st("ptr_idle", 8'h00, 1'b0, 1'b0);

        // No preemption: owner 1 keeps the grant while other bits change.
        bus.req = 8'h03;
        tick();
        expect_st("nopre_owner1", 8'h02, 1'b1, 1'b0);
        bus.req = 8'h07;
        tick();
        expect_st("nopre_hold_a", 8'h02, 1'b1, 1'b0);
        tick();
        expect_st("nopre_hold_b", 8'h02, 1'b1, 1'b0);
        bus.req = 8'h05;
        tick();
        expect_st("nopre_gap", 8'h00, 1'b0, 1'b0);
        tick();
        expect_st("nopre_next2", 8'h04, 1'b1, 1'b0);
        bus.req = 8'h00;
        tick();
        expect_st("nopre_rel_gap", 8'h00, 1'b0, 1'b0);
        tick();
        expect_st("nopre_idle", 8'h00, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a grant (ptr=3 -> owner 3).
        bus.req = 8'hFF;
        tick();
        expect_st("pre_reset_grant", 8'h08, 1'b1, 1'b0);
        reset = 1'b1;
        #2;
        expect_st("async_reset", 8'h00, 1'b0, 1'b0);
        expect_sel("async_reset_sel", 3'd0);
        reset = 1'b0;
        tick();
        expect_st("post_reset_grant0", 8'h01, 1'b1, 1'b0);

        // Round-robin wrap: each owner holds 2 cycles, drops, reasserts.
        for (int e = 0; e < 8; e++) begin
            logic [7:0] oh;
            logic [7:0] nxt;
            oh  = 8'h01 << e;
            nxt = 8'h01 << ((e + 1) % 8);
            tick();
            expect_st($sformatf("rr_hold_%0d", e), oh, 1'b1, 1'b0);
            bus.req = 8'hFF & ~oh;
            tick();
            expect_st($sformatf("rr_gap_%0d", e), 8'h00, 1'b0, 1'b0);
            bus.req = 8'hFF;
            tick();
            expect_st($sformatf("rr_next_after_%0d", e), nxt, 1'b1, 1'b0);
        end

        // Hold limit: constant req 0x81 from reset.
        reset = 1'b1;
        bus.req = 8'b1000_0001;
        #2;
        reset = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            tick();
            expect_st($sformatf("hold0_cyc%0d", c), 8'h01, 1'b1, 1'b0);
        end
        tick();
        expect_st("hold0_timeout_gap", 8'h00, 1'b0, 1'b1);
        for (int c = 1; c <= 15; c++) begin
            tick();
            expect_st($sformatf("hold7_cyc%0d", c), 8'h80, 1'b1, 1'b0);
        end
        tick();
        expect_st("hold7_timeout_gap", 8'h00, 1'b0, 1'b1);
        tick();
        expect_st("hold_back_to0", 8'h01, 1'b1, 1'b0);
        expect_sel("hold_back_sel", 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
